// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: core data-bus controller decoding ROM, RAM, GPIO/UART registers with faults and stalls
// Ports: bus_* core side (addr/wrdata/wren/rden in; rddata/ready/fault out),
//        rom_*/ram_* word-indexed memory side, gpio_out/gpio_in,
//        uart_tx_data/uart_tx_send/uart_busy transmit side, uart_rx_data/uart_rx_flag/uart_rx_clear receive side.
module mmio_bus_ctrl #(
  parameter logic [31:0] ROM_BASE   = 32'h0040_0000,
  parameter int          ROM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1001_8000,
  parameter int          MEM_RD_LAT = 0,
  parameter int          GPIO_W     = 8,
  parameter int          TXQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_wrdata,
  input  logic              bus_wren,
  input  logic              bus_rden,
  output logic [31:0]       bus_rddata,
  output logic              bus_ready,
  output logic              bus_fault,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_rddata,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_rddata,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_send,
  input  logic              uart_busy,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_flag,
  output logic              uart_rx_clear
);
  localparam int AW = $clog2(TXQ_DEPTH);
  localparam logic [31:0] ROM_N = ROM_WORDS;
  localparam logic [31:0] RAM_N = RAM_WORDS;
  typedef enum logic {IDLE, WAIT} acc_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_BUSY} tx_t;
  acc_t acc_q, acc_d;
  tx_t tx_q, tx_d;
  logic [31:0] mmio_off, mmio_rd, fault_addr;
  logic [2:0] sel;
  logic rom_hit, ram_hit, mmio_hit, idle, bad, ok_wr, ok_rd, mem_rd, wait_go;
  logic push_req, push, pop, stall, full, empty, rx_ev, rx_read;
  logic rx_valid, overrun, fault_q, seen_busy;
  logic [7:0] rx_data;
  logic [GPIO_W-1:0] gpio_q;
  logic [7:0] txq [TXQ_DEPTH];
  logic [AW:0] wp, rp;
  assign rom_addr = (bus_addr - ROM_BASE) >> 2;
  assign ram_addr = (bus_addr - RAM_BASE) >> 2;
  assign mmio_off = bus_addr - MMIO_BASE;
  assign rom_hit = rom_addr < ROM_N;
  assign ram_hit = ram_addr < RAM_N;
  assign mmio_hit = mmio_off < 32'h18;
  assign sel = mmio_off[4:2];
  assign idle = acc_q == IDLE;
  // Fault classification is meaningless in WAIT: the held access already passed decode.
  assign bad = ~(rom_hit | ram_hit | mmio_hit) | (bus_addr[1:0] != 2'b00) | (bus_wren & rom_hit)
             | (bus_wren & mmio_hit & (sel == 3'd1 | sel == 3'd3 | sel == 3'd4))
             | (bus_rden & mmio_hit & sel == 3'd2);
  assign bus_fault = idle & (bus_wren | bus_rden) & bad;
  assign ok_wr = idle & bus_wren & ~bad;
  assign ok_rd = idle & bus_rden & ~bad;
  assign mem_rd = ok_rd & (rom_hit | ram_hit);
  assign wait_go = (MEM_RD_LAT == 1) && mem_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = tx_q == T_SEND;
  assign push_req = ok_wr & mmio_hit & sel == 3'd2;
  // A pop in the same cycle frees the slot, so a full queue only stalls without one.
  assign push = push_req & (~full | pop);
  assign stall = push_req & full & ~pop;
  assign bus_ready = ~(stall | wait_go);
  assign ram_wren = ok_wr & ram_hit;
  assign ram_wrdata = bus_wrdata;
  assign rx_read = ok_rd & mmio_hit & sel == 3'd3;
  // The flag stays high until the UART sees our clear pulse; ignore it during that cycle.
  assign rx_ev = uart_rx_flag & ~uart_rx_clear;
  assign uart_tx_send = pop;
  assign uart_tx_data = pop ? txq[rp[AW-1:0]] : 8'h00;
  assign gpio_out = gpio_q;
  always_comb begin
    mmio_rd = sel == 3'd0 ? 32'(gpio_q)
            : sel == 3'd1 ? 32'(gpio_in)
            : sel == 3'd3 ? {24'b0, rx_data}
            : sel == 3'd4 ? {26'b0, overrun, fault_q, uart_busy, rx_valid, empty, full}
            : sel == 3'd5 ? fault_addr : 32'h0;
    bus_rddata = !idle ? (rom_hit ? rom_rddata : ram_rddata)
               : (!ok_rd || wait_go) ? 32'h0
               : rom_hit ? rom_rddata : ram_hit ? ram_rddata : mmio_rd;
  end
  always_comb begin
    acc_d = IDLE;
    if (wait_go) acc_d = WAIT;
  end
  always_comb begin
    tx_d = tx_q;
    case (tx_q)
      T_IDLE: if (!empty && !uart_busy) tx_d = T_SEND;
      T_SEND: tx_d = T_BUSY;
      T_BUSY: if (seen_busy && !uart_busy) tx_d = T_IDLE;
      default: tx_d = T_IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) txq[wp[AW-1:0]] <= bus_wrdata[7:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= IDLE;
      tx_q <= T_IDLE;
      wp <= '0;
      rp <= '0;
      seen_busy <= 1'b0;
      gpio_q <= '0;
      rx_data <= 8'h00;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      uart_rx_clear <= 1'b0;
      fault_q <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      acc_q <= acc_d;
      tx_q <= tx_d;
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (pop) seen_busy <= 1'b0;
      else if (tx_q == T_BUSY && uart_busy) seen_busy <= 1'b1;
      if (ok_wr && mmio_hit && sel == 3'd0) gpio_q <= bus_wrdata[GPIO_W-1:0];
      uart_rx_clear <= rx_ev;
      if (rx_ev && (!rx_valid || rx_read)) begin
        rx_data <= uart_rx_data;
        rx_valid <= 1'b1;
        overrun <= 1'b0;
      end else if (rx_ev) begin
        overrun <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
        overrun <= 1'b0;
      end
      if (bus_fault) begin
        fault_q <= 1'b1;
        if (!fault_q) fault_addr <= bus_addr;
      end else if (ok_wr && mmio_hit && sel == 3'd5) begin
        fault_q <= 1'b0;
        fault_addr <= 32'h0;
      end
    end
  end
endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised successor to the single-cycle memory controller; sits between the core's data bus and ROM, RAM, GPIO and UART.
- Adds sized and bounds-checked ROM/RAM windows and a configurable memory read latency with a bus_ready stall.
- Adds a buffered UART TX queue, a latched UART RX register, a sticky fault register, and an internal GPIO output register.

Parameters:
- ROM_BASE, 32'h0040_0000, byte base of ROM window
- ROM_WORDS, 1024, ROM depth in 32-bit words
- RAM_BASE, 32'h1001_0000, byte base of RAM window
- RAM_WORDS, 1024, RAM depth in words
- MMIO_BASE, 32'h1001_8000, byte base of register block (6 words)
- MEM_RD_LAT, 0, ROM/RAM read latency in cycles; legal values 0 or 1
- GPIO_W, 8, GPIO in/out width
- TXQ_DEPTH, 4, UART TX FIFO depth; power of 2, ≥2

Ports:
- clk in 1 clock
- rst in 1 synchronous active-high reset
- bus_addr in 32 byte address
- bus_wrdata in 32 write data
- bus_wren in 1 write strobe
- bus_rden in 1 read strobe
- bus_rddata out 32 read data, valid when bus_ready=1
- bus_ready out 1 access completes this cycle
- bus_fault out 1 one-cycle pulse on illegal access
- rom_addr out 32 ROM word index
- rom_rddata in 32
- ram_addr out 32 RAM word index
- ram_wrdata out 32 equals bus_wrdata
- ram_wren out 1
- ram_rddata in 32
- gpio_out out GPIO_W registered output
- gpio_in in GPIO_W
- uart_tx_data out 8
- uart_tx_send out 1 one-cycle start pulse
- uart_busy in 1
- uart_rx_data in 8
- uart_rx_flag in 1
- uart_rx_clear out 1 one-cycle acknowledge pulse

Behaviour:
- Reset values: all outputs 0; bus_ready=1; TX FIFO empty; rx_valid/overrun/fault cleared; FAULT_ADDR=0; both FSMs in IDLE. Reset mid-transfer flushes the FIFO and drops any pending send.
- Decode:
  - rom_addr=(bus_addr-ROM_BASE)>>2; ram_addr=(bus_addr-RAM_BASE)>>2.
  - A region hits when its word index < its *_WORDS.
  - MMIO hits at offsets 0x00–0x14.
  - Anything else is unmapped.
- MMIO map:
  - +0x00 GPIO_OUT: RW.
  - +0x04 GPIO_IN: RO, zero-extended.
  - +0x08 UART_TX: WO; pushes wrdata[7:0].
  - +0x0C UART_RX: RO; returns {24'b0,rx_data}; clears rx_valid and overrun.
  - +0x10 STATUS: RO; bit0 txq_full, bit1 txq_empty, bit2 rx_valid, bit3 uart_busy, bit4 fault, bit5 overrun.
  - +0x14 FAULT_ADDR: read returns the address; any write clears fault and FAULT_ADDR.
- Faults: unmapped address, addr[1:0]≠0, ROM write, write to a RO register, or read of UART_TX.
  - Effects: bus_fault=1 for that cycle, bus_ready=1, rddata=0, no side effects.
  - Sets sticky fault; FAULT_ADDR captures only the first fault since clear.
- Access FSM (IDLE/WAIT):
  - MEM_RD_LAT=0: all accesses complete in the same cycle.
  - MEM_RD_LAT=1: a ROM/RAM read takes IDLE→WAIT with bus_ready=0 that cycle. In WAIT, bus_ready=1, rddata=memory data, then →IDLE. Bus inputs are held by the master during WAIT.
  - Writes and MMIO accesses never enter WAIT.
  - ram_wren = bus_wren & RAM hit & no fault.
- TX FIFO:
  - A push when full stalls: bus_ready=0 until a slot frees. The push then commits in the cycle bus_ready=1.
  - A push and a pop in the same cycle while full is legal; no stall.
- TX drain FSM (T_IDLE→T_SEND→T_BUSY→T_IDLE):
  - T_IDLE: FIFO non-empty and uart_busy=0 → T_SEND.
  - T_SEND: uart_tx_send=1 for exactly 1 cycle with uart_tx_data=head; pop; → T_BUSY.
  - T_BUSY: wait for uart_busy 1 then 0, then → T_IDLE.
- RX:
  - On uart_rx_flag=1 with rx_valid=0: capture uart_rx_data, set rx_valid, pulse uart_rx_clear the next cycle.
  - If rx_valid=1 when the flag arrives: keep old data, set overrun, still pulse uart_rx_clear.
  - Same-cycle UART_RX read and new flag: the read returns old data; new data is captured; rx_valid stays 1.

Test Plan:
- MEM_RD_LAT=1, read RAM_BASE+0x8 with ram_rddata=32'hCAFE_0001 → cycle0 ready=0, ram_addr=2; cycle1 ready=1, rddata=32'hCAFE_0001.
- Write 0x41,0x42,0x43,0x44,0x45 to UART_TX with uart_busy held 1 (TXQ_DEPTH=4) → 5th write stalls (ready=0). Drop busy → sends 0x41..0x45 in order, one send pulse each.
- Write ROM_BASE, then read RAM_BASE+4*RAM_WORDS → bus_fault pulses both times, ram_wren=0. FAULT_ADDR=32'h0040_0000, STATUS bit4=1. Write FAULT_ADDR → STATUS bit4=0.
- rx_flag with data 0x5A, then rx_flag with 0x33 before any read → UART_RX reads 0x5A, STATUS bit5=1 before the read and 0 after; two uart_rx_clear pulses.
- Write GPIO_OUT=32'hFF5 (GPIO_W=8) → gpio_out=8'hF5; assert rst mid-stall from the TX test → all outputs and FIFO return to reset values next cycle.
- Read bus_addr=RAM_BASE+2 → fault, rddata=0, no RAM access.
